// File: rtl/ap_ctrl_multi_monitor.sv
// ap_ctrl_multi_monitor: per-channel ap_ctrl handshake tracker with saturating
// performance counters, sticky protocol-error flags and a registered readout port.
module ap_ctrl_multi_monitor #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned CH_W   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              finish,
  input  logic              clear,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] proto_err,
  output logic              all_idle,
  output logic              frozen
);

  localparam int unsigned ST_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Saturating increment shared by every counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // ap_ready carries no tracked meaning; fold it away explicitly.
  logic unused_ap_ready_c;
  assign unused_ap_ready_c = ^ap_ready;

  state_t           state_q     [NUM_CH];
  state_t           state_d     [NUM_CH];
  logic [CNT_W-1:0] cur_lat_q   [NUM_CH];
  logic [CNT_W-1:0] cur_lat_d   [NUM_CH];
  logic [CNT_W-1:0] txn_cnt_q   [NUM_CH];
  logic [CNT_W-1:0] txn_cnt_d   [NUM_CH];
  logic [CNT_W-1:0] last_lat_q  [NUM_CH];
  logic [CNT_W-1:0] last_lat_d  [NUM_CH];
  logic [CNT_W-1:0] max_lat_q   [NUM_CH];
  logic [CNT_W-1:0] max_lat_d   [NUM_CH];
  logic [CNT_W-1:0] min_lat_q   [NUM_CH];
  logic [CNT_W-1:0] min_lat_d   [NUM_CH];
  logic [CNT_W-1:0] busy_cyc_q  [NUM_CH];
  logic [CNT_W-1:0] busy_cyc_d  [NUM_CH];
  logic [CNT_W-1:0] stall_cyc_q [NUM_CH];
  logic [CNT_W-1:0] stall_cyc_d [NUM_CH];
  logic [CNT_W-1:0] lat_fin_c   [NUM_CH];
  logic [NUM_CH-1:0] err_q, err_d;
  logic [NUM_CH-1:0] active_c, done_ev_c;

  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              frozen_q, frozen_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic [NUM_CH-1:0] ch_busy_q, ch_busy_d;
  logic              all_idle_q, all_idle_d;

  assign rd_data   = rd_data_q;
  assign ch_busy   = ch_busy_q;
  assign proto_err = err_q;
  assign all_idle  = all_idle_q;
  assign frozen    = frozen_q;

  // State and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        state_q[i]     <= ST_IDLE;
        cur_lat_q[i]   <= '0;
        txn_cnt_q[i]   <= '0;
        last_lat_q[i]  <= '0;
        max_lat_q[i]   <= '0;
        min_lat_q[i]   <= CNT_MAX;
        busy_cyc_q[i]  <= '0;
        stall_cyc_q[i] <= '0;
      end
      err_q      <= '0;
      cyc_q      <= '0;
      frozen_q   <= 1'b0;
      rd_data_q  <= '0;
      ch_busy_q  <= '0;
      all_idle_q <= 1'b1;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        state_q[i]     <= state_d[i];
        cur_lat_q[i]   <= cur_lat_d[i];
        txn_cnt_q[i]   <= txn_cnt_d[i];
        last_lat_q[i]  <= last_lat_d[i];
        max_lat_q[i]   <= max_lat_d[i];
        min_lat_q[i]   <= min_lat_d[i];
        busy_cyc_q[i]  <= busy_cyc_d[i];
        stall_cyc_q[i] <= stall_cyc_d[i];
      end
      err_q      <= err_d;
      cyc_q      <= cyc_d;
      frozen_q   <= frozen_d;
      rd_data_q  <= rd_data_d;
      ch_busy_q  <= ch_busy_d;
      all_idle_q <= all_idle_d;
    end
  end

  // Per-channel FSM next state, latency tracking and counter updates.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      state_d[i]     = state_q[i];
      cur_lat_d[i]   = cur_lat_q[i];
      txn_cnt_d[i]   = txn_cnt_q[i];
      last_lat_d[i]  = last_lat_q[i];
      max_lat_d[i]   = max_lat_q[i];
      min_lat_d[i]   = min_lat_q[i];
      busy_cyc_d[i]  = busy_cyc_q[i];
      stall_cyc_d[i] = stall_cyc_q[i];
      lat_fin_c[i]   = '0;
      err_d[i]       = err_q[i];
      active_c[i]    = 1'b0;
      done_ev_c[i]   = 1'b0;

      if (clear) begin
        state_d[i]     = ST_IDLE;
        cur_lat_d[i]   = '0;
        txn_cnt_d[i]   = '0;
        last_lat_d[i]  = '0;
        max_lat_d[i]   = '0;
        min_lat_d[i]   = CNT_MAX;
        busy_cyc_d[i]  = '0;
        stall_cyc_d[i] = '0;
        err_d[i]       = 1'b0;
      end else if (!frozen_q) begin
        unique case (state_q[i])
          ST_IDLE: begin
            if (ap_start[i]) begin
              // The start cycle is the first latency and busy cycle.
              active_c[i]  = 1'b1;
              cur_lat_d[i] = CNT_ONE;
              state_d[i]   = ST_RUN;
              if (ap_done[i]) begin
                done_ev_c[i] = 1'b1;
                lat_fin_c[i] = CNT_ONE;
                state_d[i]   = ap_continue[i] ? ST_IDLE : ST_HOLD;
              end
            end else if (ap_done[i]) begin
              err_d[i] = 1'b1;
            end
          end
          ST_RUN: begin
            active_c[i]  = 1'b1;
            cur_lat_d[i] = sat_inc(cur_lat_q[i]);
            if (ap_done[i]) begin
              done_ev_c[i] = 1'b1;
              lat_fin_c[i] = sat_inc(cur_lat_q[i]);
              state_d[i]   = ap_continue[i] ? ST_IDLE : ST_HOLD;
            end
          end
          ST_HOLD: begin
            active_c[i]    = 1'b1;
            stall_cyc_d[i] = sat_inc(stall_cyc_q[i]);
            if (ap_done[i]) begin
              err_d[i] = 1'b1;
            end
            if (ap_continue[i]) begin
              state_d[i] = ST_IDLE;
            end
          end
          default: state_d[i] = ST_IDLE;
        endcase

        if (active_c[i]) begin
          busy_cyc_d[i] = sat_inc(busy_cyc_q[i]);
        end

        // Completion bookkeeping.
        if (done_ev_c[i]) begin
          txn_cnt_d[i]  = sat_inc(txn_cnt_q[i]);
          last_lat_d[i] = lat_fin_c[i];
          if (lat_fin_c[i] > max_lat_q[i]) begin
            max_lat_d[i] = lat_fin_c[i];
          end
          if (lat_fin_c[i] < min_lat_q[i]) begin
            min_lat_d[i] = lat_fin_c[i];
          end
        end
      end
    end
  end

  // Global cycle counter, freeze flag and registered status outputs.
  always_comb begin
    cyc_d      = cyc_q;
    frozen_d   = frozen_q;
    ch_busy_d  = ch_busy_q;
    all_idle_d = all_idle_q;

    if (clear) begin
      cyc_d      = '0;
      frozen_d   = 1'b0;
      ch_busy_d  = '0;
      all_idle_d = 1'b1;
    end else if (!frozen_q) begin
      cyc_d      = sat_inc(cyc_q);
      frozen_d   = finish;
      ch_busy_d  = active_c;
      all_idle_d = ~|active_c;
    end
  end

  // Readout mux; out-of-range channels read as zero.
  always_comb begin
    rd_data_d = '0;
    if (!clear) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (rd_ch == CH_W'(i)) begin
          unique case (rd_sel)
            3'd0:    rd_data_d = txn_cnt_q[i];
            3'd1:    rd_data_d = last_lat_q[i];
            3'd2:    rd_data_d = max_lat_q[i];
            3'd3:    rd_data_d = min_lat_q[i];
            3'd4:    rd_data_d = busy_cyc_q[i];
            3'd5:    rd_data_d = stall_cyc_q[i];
            3'd6:    rd_data_d = CNT_W'({state_q[i], err_q[i]});
            default: rd_data_d = cyc_q;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ap_ctrl_multi_monitor.sv
// Directed bench for ap_ctrl_multi_monitor with 8-bit counters (saturation reachable).
module tb_ap_ctrl_multi_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] ap_start = '0;
  logic [3:0] ap_ready = '0;
  logic [3:0] ap_done = '0;
  logic [3:0] ap_continue = 4'hF;
  logic       finish = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] rd_ch = '0;
  logic [2:0] rd_sel = '0;
  logic [7:0] rd_data, rd_data3;
  logic [3:0] ch_busy, proto_err;
  logic [2:0] ch_busy3, proto_err3;
  logic       all_idle, frozen, all_idle3, frozen3;

  int n_checks = 0;
  int n_fail   = 0;
  int bc;

  always #5 clock = ~clock;

  ap_ctrl_multi_monitor #(.NUM_CH(4), .CNT_W(8), .CH_W(2)) u_dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .clear(clear),
    .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data), .ch_busy(ch_busy),
    .proto_err(proto_err), .all_idle(all_idle), .frozen(frozen)
  );

  // Three-channel instance so that rd_ch == NUM_CH is expressible.
  ap_ctrl_multi_monitor #(.NUM_CH(3), .CNT_W(8), .CH_W(2)) u_dut3 (
    .clock(clock), .reset(reset), .ap_start(ap_start[2:0]), .ap_ready(ap_ready[2:0]),
    .ap_done(ap_done[2:0]), .ap_continue(ap_continue[2:0]), .finish(finish), .clear(clear),
    .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data3), .ch_busy(ch_busy3),
    .proto_err(proto_err3), .all_idle(all_idle3), .frozen(frozen3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd_chk(input int ch, input int sel, input int exp, input string tag);
    rd_ch  = 2'(ch);
    rd_sel = 3'(sel);
    tick();
    check_eq(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic rd_chk3(input int ch, input int sel, input int exp, input string tag);
    rd_ch  = 2'(ch);
    rd_sel = 3'(sel);
    tick();
    check_eq(tag, 32'(rd_data3), 32'(exp));
  endtask

  // One transaction: start at cycle 0, done at cycle lat-1, continue low for
  // hold cycles starting at the done cycle. Returns the ch_busy high count.
  task automatic run_txn(input int ch, input int lat, input int hold, output int busy_n);
    int d;
    d = lat - 1;
    busy_n = 0;
    for (int c = 0; c <= d + hold; c++) begin
      ap_start[ch]    = (c == 0);
      ap_done[ch]     = (c == d);
      ap_continue[ch] = !(hold > 0 && c >= d && c < d + hold);
      if (hold > 0 && c == d + 1) begin
        rd_ch  = 2'(ch);
        rd_sel = 3'd6;
      end
      tick();
      busy_n += int'(ch_busy[ch]);
      if (hold > 0 && c == d + 1) check_eq("hold_status", 32'(rd_data), 32'd4);
    end
    ap_start[ch]    = 1'b0;
    ap_done[ch]     = 1'b0;
    ap_continue[ch] = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("rst_ch_busy", 32'(ch_busy), 32'd0);
    check_eq("rst_proto_err", 32'(proto_err), 32'd0);
    check_eq("rst_all_idle", 32'(all_idle), 32'd1);
    check_eq("rst_frozen", 32'(frozen), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b1;
    repeat (8) tick();

    // Ch0: latency-5 transaction
    run_txn(0, 5, 0, bc);
    check_eq("ch0_busy_cycles", 32'(bc), 32'd5);
    tick();
    check_eq("ch0_busy_after", 32'(ch_busy[0]), 32'd0);
    check_eq("ch0_all_idle", 32'(all_idle), 32'd1);
    rd_chk(0, 0, 1, "ch0_txn");
    rd_chk(0, 1, 5, "ch0_last");
    rd_chk(0, 2, 5, "ch0_max");
    rd_chk(0, 3, 5, "ch0_min");
    rd_chk(0, 4, 5, "ch0_busy");
    rd_chk(0, 5, 0, "ch0_stall");
    rd_chk(0, 6, 0, "ch0_status");

    // Ch1: latencies 3 and 7, then one with a 4-cycle stall
    run_txn(1, 3, 0, bc);
    run_txn(1, 7, 0, bc);
    rd_chk(1, 0, 2, "ch1_txn2");
    rd_chk(1, 3, 3, "ch1_min");
    rd_chk(1, 2, 7, "ch1_max");
    rd_chk(1, 1, 7, "ch1_last");
    run_txn(1, 3, 4, bc);
    rd_chk(1, 5, 4, "ch1_stall");
    rd_chk(1, 0, 3, "ch1_txn3");
    rd_chk(1, 4, 17, "ch1_busy");
    rd_chk(1, 1, 3, "ch1_last3");
    rd_chk(1, 6, 0, "ch1_status_idle");

    // Ch2: start and done together, then a stray done in IDLE
    run_txn(2, 1, 0, bc);
    rd_chk(2, 0, 1, "ch2_txn");
    rd_chk(2, 1, 1, "ch2_last");
    rd_chk(2, 4, 1, "ch2_busy");
    rd_chk(2, 6, 0, "ch2_status");
    check_eq("ch2_err_clean", 32'(proto_err[2]), 32'd0);
    ap_done[2] = 1'b1;
    tick();
    ap_done[2] = 1'b0;
    tick();
    check_eq("ch2_err_set", 32'(proto_err[2]), 32'd1);
    rd_chk(2, 6, 1, "ch2_status_err");

    // Ch3: 300-cycle run saturates 8-bit counters
    run_txn(3, 300, 0, bc);
    rd_chk(3, 4, 255, "ch3_busy_sat");
    rd_chk(3, 1, 255, "ch3_last_sat");
    rd_chk(3, 2, 255, "ch3_max_sat");
    rd_chk(3, 0, 1, "ch3_txn");
    rd_chk(0, 7, 255, "cyc_sat");
    rd_chk3(3, 0, 0, "dut3_rd_oor");
    rd_chk3(0, 0, 1, "dut3_ch0_txn");

    // Finish mid-transaction on ch0
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    tick();
    tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    check_eq("frozen_set", 32'(frozen), 32'd1);
    ap_done[0]  = 1'b1;
    ap_start[1] = 1'b1;
    repeat (3) tick();
    ap_done[0]  = 1'b0;
    ap_start[1] = 1'b0;
    repeat (47) tick();
    rd_chk(0, 0, 1, "frz_ch0_txn");
    rd_chk(0, 4, 9, "frz_ch0_busy");
    rd_chk(0, 6, 2, "frz_ch0_status");
    rd_chk(1, 0, 3, "frz_ch1_txn");
    check_eq("frz_ch_busy", 32'(ch_busy), 32'd1);
    check_eq("frz_all_idle", 32'(all_idle), 32'd0);
    check_eq("frz_still", 32'(frozen), 32'd1);

    // Clear
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_frozen", 32'(frozen), 32'd0);
    check_eq("clr_all_idle", 32'(all_idle), 32'd1);
    check_eq("clr_ch_busy", 32'(ch_busy), 32'd0);
    check_eq("clr_proto_err", 32'(proto_err), 32'd0);
    check_eq("clr_rd_data", 32'(rd_data), 32'd0);
    rd_chk(0, 7, 0, "clr_cyc0");
    rd_chk(0, 7, 1, "clr_cyc1");
    rd_chk(0, 0, 0, "clr_ch0_txn");
    rd_chk(0, 3, 255, "clr_ch0_min");
    rd_chk(2, 6, 0, "clr_ch2_status");

    // Asynchronous reset while ch0 is in RUN
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    tick();
    tick();
    rd_chk(0, 4, 3, "pre_rst_busy");
    reset = 1'b0;
    #1;
    check_eq("arst_ch_busy", 32'(ch_busy), 32'd0);
    check_eq("arst_rd_data", 32'(rd_data), 32'd0);
    check_eq("arst_all_idle", 32'(all_idle), 32'd1);
    check_eq("arst_rd_data3", 32'(rd_data3), 32'd0);
    #1;
    reset = 1'b1;
    tick();
    rd_chk(0, 6, 0, "post_rst_status");
    rd_chk(0, 4, 0, "post_rst_busy");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
